fb_swap_controller: RTL and testbench

//  Sequences the back-buffer -> front-buffer frame copy: waits for the processor's

---
 rtl/fb_swap_controller_if.sv | 36 +++
 rtl/fb_swap_controller.sv | 116 +++++++++++
 tb/tb_fb_swap_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_swap_controller_if.sv
// rtl/fb_swap_controller_if.sv - processor, back/front buffer and VGA trigger signals of fb_swap_controller
interface fb_swap_controller_if #(
    parameter int AW = 17,
    parameter int CW = 5
);
    logic          enable;
    logic          trigger;
    logic          done;
    logic          proc_we;
    logic [AW-1:0] proc_waddr;
    logic [CW-1:0] proc_din;
    logic          bb_we;
    logic [AW-1:0] bb_waddr;
    logic [CW-1:0] bb_din;
    logic [AW-1:0] bb_raddr;
    logic [CW-1:0] bb_rdata;
    logic          fb_we;
    logic [AW-1:0] fb_waddr;
    logic [CW-1:0] fb_din;
    logic          swap;
    logic          busy;
    logic          overrun;
    logic [7:0]    frame_count;

    modport slave (
        input  enable, trigger, done, proc_we, proc_waddr, proc_din, bb_rdata,
        output bb_we, bb_waddr, bb_din, bb_raddr, fb_we, fb_waddr, fb_din,
               swap, busy, overrun, frame_count
    );

    modport master (
        output enable, trigger, done, proc_we, proc_waddr, proc_din, bb_rdata,
        input  bb_we, bb_waddr, bb_din, bb_raddr, fb_we, fb_waddr, fb_din,
               swap, busy, overrun, frame_count
    );
endinterface

// File: rtl/fb_swap_controller.sv
// rtl/fb_swap_controller.sv - frame-aligned back-to-front buffer copy with 4-phase swap handshake
module fb_swap_controller #(
    parameter int NUMBER_COLORS = 9,
    parameter int H_RES         = 320,
    parameter int V_RES         = 240,
    parameter int READ_LATENCY  = 1,
    localparam int CW = $clog2(NUMBER_COLORS) + 1,
    localparam int N  = H_RES * V_RES,
    localparam int AW = $clog2(N)
) (
    input  logic CLOCK_50,
    input  logic resetn,
    fb_swap_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COPY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam int DW = $clog2(READ_LATENCY + 1);

    logic [1:0]    state;
    logic [AW-1:0] addr;
    logic [DW-1:0] drain_cnt;
    logic          trig_q;
    logic          frame_edge;
    logic          copying;
    logic          swap_q;
    logic          busy_q;
    logic          overrun_q;
    logic [7:0]    count_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [AW-1:0] adr_q [READ_LATENCY];

    // Copies start on the falling edge of the VGA frame trigger
    assign frame_edge = trig_q & ~bus.trigger;
    assign copying    = (state == S_COPY) || (state == S_DRAIN);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            addr      <= '0;
            drain_cnt <= '0;
            trig_q    <= 1'b0;
            swap_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            trig_q <= bus.trigger;
            busy_q <= copying;
            swap_q <= (state == S_ACK);
            if (copying && bus.proc_we)
                overrun_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.done && bus.enable && frame_edge) begin
                        state <= S_COPY;
                        addr  <= '0;
                    end
                end
                S_COPY: begin
                    if (addr == LAST) begin
                        state     <= S_DRAIN;
                        addr      <= '0;
                        drain_cnt <= '0;
                    end else begin
                        addr <= addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(READ_LATENCY - 1)) begin
                        state   <= S_ACK;
                        count_q <= count_q + 8'd1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_ACK: begin
                    // swap_q lags state by one cycle, so swap is seen even if done is already low
                    if (!bus.done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address and valid travel alongside the read so each write lands with its own data
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                adr_q[i] <= '0;
        end else begin
            vld_q[0] <= (state == S_COPY);
            adr_q[0] <= addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                adr_q[i] <= adr_q[i-1];
            end
        end
    end

    assign bus.bb_raddr    = addr;
    assign bus.bb_we       = copying ? 1'b0 : bus.proc_we;
    assign bus.bb_waddr    = bus.proc_waddr;
    assign bus.bb_din      = bus.proc_din;
    assign bus.fb_we       = vld_q[READ_LATENCY-1];
    assign bus.fb_waddr    = adr_q[READ_LATENCY-1];
    assign bus.fb_din      = bus.bb_rdata[CW-1:0];
    assign bus.swap        = swap_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_fb_swap_controller.sv
// tb/tb_fb_swap_controller.sv - checks fb_swap_controller at read latencies 1 and 3
`timescale 1ns/1ps
module tb_fb_swap_controller;
    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int CW   = 5;
    localparam int CMAX = N + 14;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [CW-1:0] din;
        logic          exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          enable, trigger, done, proc_we;
    logic [AW-1:0] proc_waddr;
    logic [CW-1:0] proc_din;
    logic [CW-1:0] mem [N];
    logic [AW-1:0] ra_a;
    logic [AW-1:0] rb [3];

    fb_swap_controller_if #(.AW(AW), .CW(CW)) ifa ();
    fb_swap_controller_if #(.AW(AW), .CW(CW)) ifb ();

    fb_swap_controller #(.NUMBER_COLORS(9), .H_RES(4), .V_RES(2), .READ_LATENCY(1)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .bus(ifa.slave));
    fb_swap_controller #(.NUMBER_COLORS(9), .H_RES(4), .V_RES(2), .READ_LATENCY(3)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .bus(ifb.slave));

    assign ifa.enable = enable;     assign ifb.enable = enable;
    assign ifa.trigger = trigger;   assign ifb.trigger = trigger;
    assign ifa.done = done;         assign ifb.done = done;
    assign ifa.proc_we = proc_we;   assign ifb.proc_we = proc_we;
    assign ifa.proc_waddr = proc_waddr; assign ifb.proc_waddr = proc_waddr;
    assign ifa.proc_din = proc_din; assign ifb.proc_din = proc_din;

    // Back-buffer memory with 1-cycle and 3-cycle read latency
    always @(posedge clk) begin
        ra_a  <= ifa.bb_raddr;
        rb[0] <= ifb.bb_raddr;
        rb[1] <= rb[0];
        rb[2] <= rb[1];
    end
    assign ifa.bb_rdata = mem[ra_a];
    assign ifb.bb_rdata = mem[rb[2]];

    logic          o_bb_we [2], o_fb_we [2], o_swap [2], o_busy [2], o_ovr [2];
    logic [AW-1:0] o_bb_waddr [2], o_raddr [2], o_fb_waddr [2];
    logic [CW-1:0] o_bb_din [2], o_fb_din [2];
    logic [7:0]    o_cnt [2];
    assign o_bb_we[0] = ifa.bb_we;       assign o_bb_we[1] = ifb.bb_we;
    assign o_fb_we[0] = ifa.fb_we;       assign o_fb_we[1] = ifb.fb_we;
    assign o_swap[0] = ifa.swap;         assign o_swap[1] = ifb.swap;
    assign o_busy[0] = ifa.busy;         assign o_busy[1] = ifb.busy;
    assign o_ovr[0] = ifa.overrun;       assign o_ovr[1] = ifb.overrun;
    assign o_bb_waddr[0] = ifa.bb_waddr; assign o_bb_waddr[1] = ifb.bb_waddr;
    assign o_raddr[0] = ifa.bb_raddr;    assign o_raddr[1] = ifb.bb_raddr;
    assign o_fb_waddr[0] = ifa.fb_waddr; assign o_fb_waddr[1] = ifb.fb_waddr;
    assign o_bb_din[0] = ifa.bb_din;     assign o_bb_din[1] = ifb.bb_din;
    assign o_fb_din[0] = ifa.fb_din;     assign o_fb_din[1] = ifb.fb_din;
    assign o_cnt[0] = ifa.frame_count;   assign o_cnt[1] = ifb.frame_count;

    int   n_chk = 0;
    int   n_pass = 0;
    int   fc_exp [2];
    logic ovr_exp [2];
    vec_t vt [6];

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    endtask

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic apply_table();
        enable = 1'b0; done = 1'b0; trigger = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            proc_we = vt[v].we; proc_waddr = vt[v].wa; proc_din = vt[v].din;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("idle_bb_we", i, o_bb_we[i], vt[v].exp_we);
                chk("idle_bb_waddr", i, o_bb_waddr[i], vt[v].wa);
                chk("idle_bb_din", i, o_bb_din[i], vt[v].din);
                chk("idle_overrun", i, o_ovr[i], ovr_exp[i]);
            end
        end
        @(posedge clk); #1; proc_we = 1'b0;
    endtask

    // One frame period: trigger falls in cycle 0, done drops from cycle dd on
    task automatic run(input bit en, input bit dn, input int dd);
        bit go;
        go = en && dn;
        @(posedge clk); #1;
        trigger = 1'b1; done = 1'b0; proc_we = 1'b0; enable = en;
        for (int k = 0; k < N; k++) mem[k] = CW'($urandom);
        for (int c = 0; c <= CMAX; c++) begin
            @(posedge clk); #1;
            trigger    = (c >= 2) ? 1'($urandom) : 1'b0;
            done       = dn && (c < dd);
            enable     = (go && c > 0) ? 1'($urandom) : en;
            proc_we    = ($urandom_range(0, 3) == 0);
            proc_waddr = AW'($urandom);
            proc_din   = CW'($urandom);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int rl, a, d;
                bit cp, w;
                rl = rl_of(i);
                a  = N + rl + 1;
                d  = (dd > a) ? dd : a;
                cp = go && c >= 1 && c <= N + rl;
                w  = go && c >= 1 + rl && c <= N + rl;
                chk("busy", i, o_busy[i], go && c >= 2 && c <= N + rl + 1);
                chk("swap", i, o_swap[i], go && c >= a + 1 && c <= d + 1);
                chk("fb_we", i, o_fb_we[i], w);
                if (w) begin
                    chk("fb_waddr", i, o_fb_waddr[i], c - 1 - rl);
                    chk("fb_din", i, o_fb_din[i], mem[c - 1 - rl]);
                end
                if (go && c >= 1 && c <= N)
                    chk("bb_raddr", i, o_raddr[i], c - 1);
                chk("bb_we", i, o_bb_we[i], cp ? 1'b0 : proc_we);
                chk("bb_waddr", i, o_bb_waddr[i], proc_waddr);
                if (cp && proc_we) ovr_exp[i] = 1'b1;
                if (go && c == a) fc_exp[i] = (fc_exp[i] + 1) % 256;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("frame_count", i, o_cnt[i], fc_exp[i]);
            chk("overrun", i, o_ovr[i], ovr_exp[i]);
        end
    endtask

    task automatic mid_copy_reset();
        @(posedge clk); #1;
        trigger = 1'b1; done = 1'b0; proc_we = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0; done = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) chk("raddr_before_reset", i, o_raddr[i], 3);
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, o_busy[i], 0);
            chk("rst_swap", i, o_swap[i], 0);
            chk("rst_fb_we", i, o_fb_we[i], 0);
            chk("rst_overrun", i, o_ovr[i], 0);
            chk("rst_count", i, o_cnt[i], 0);
            chk("rst_raddr", i, o_raddr[i], 0);
            chk("rst_bb_we", i, o_bb_we[i], 0);
            fc_exp[i] = 0;
            ovr_exp[i] = 1'b0;
        end
        done = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b1, 3'd5, 5'd17, 1'b1};
        vt[1] = '{1'b0, 3'd2, 5'd3,  1'b0};
        vt[2] = '{1'b1, 3'd0, 5'd0,  1'b1};
        vt[3] = '{1'b1, 3'd7, 5'd31, 1'b1};
        vt[4] = '{1'b0, 3'd7, 5'd31, 1'b0};
        vt[5] = '{1'b1, 3'd3, 5'd10, 1'b1};
        enable = 1'b0; trigger = 1'b0; done = 1'b0; proc_we = 1'b0;
        proc_waddr = '0; proc_din = '0;
        for (int k = 0; k < N; k++) mem[k] = '0;
        for (int i = 0; i < 2; i++) begin fc_exp[i] = 0; ovr_exp[i] = 1'b0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, o_busy[i], 0);
            chk("reset_swap", i, o_swap[i], 0);
            chk("reset_fb_we", i, o_fb_we[i], 0);
            chk("reset_overrun", i, o_ovr[i], 0);
            chk("reset_count", i, o_cnt[i], 0);
            chk("reset_raddr", i, o_raddr[i], 0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;

        apply_table();
        run(1'b1, 1'b1, N + 10);
        run(1'b1, 1'b1, 1);
        run(1'b0, 1'b1, N + 12);
        run(1'b1, 1'b0, 5);
        run(1'b1, 1'b1, $urandom_range(1, N + 12));
        apply_table();
        mid_copy_reset();
        repeat (256) run(1'b1, 1'b1, $urandom_range(1, N + 12));
        apply_table();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
